// File: rtl/m68k_bus_arbiter_pkg.sv
// m68k_bus_arbiter_pkg: shared arbiter state encoding and Pi status bit positions
//   ARB_ST_*        : arbiter state codes exported on arb_state
//   arb_state_e     : typed FSM state built from the ARB_ST_* codes
//   STAT_*_BIT      : Pi status word bit positions of the sticky arbiter flags
//   bus_quiet()     : true when no cycle or other master is active on the bus
package m68k_bus_arbiter_pkg;

   localparam logic [2:0] ARB_ST_IDLE      = 3'd0;
   localparam logic [2:0] ARB_ST_REQ       = 3'd1;
   localparam logic [2:0] ARB_ST_WAIT_FREE = 3'd2;
   localparam logic [2:0] ARB_ST_ACQ       = 3'd3;
   localparam logic [2:0] ARB_ST_OWNED     = 3'd4;
   localparam logic [2:0] ARB_ST_REL       = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE      = ARB_ST_IDLE,
      ST_REQ       = ARB_ST_REQ,
      ST_WAIT_FREE = ARB_ST_WAIT_FREE,
      ST_ACQ       = ARB_ST_ACQ,
      ST_OWNED     = ARB_ST_OWNED,
      ST_REL       = ARB_ST_REL
   } arb_state_e;

   localparam int STAT_GRANT_TMO_BIT = 8;
   localparam int STAT_ABORT_BIT     = 9;

   // All three bus strobes are active-low; the bus is free only when every one is released.
   function automatic logic bus_quiet(input logic nas, input logic ndtack, input logic nbgack);
      return nas & ndtack & nbgack;
   endfunction

endpackage

// File: rtl/m68k_bus_arbiter.sv
// m68k_bus_arbiter: 68000 BR/BG/BGACK bus mastership handshake for the Pi bus access engine
//   sys_clk, sys_rst            : single clock domain, synchronous active-high reset
//   mc_clk_rising/falling       : 1-cycle strobes marking the 7 MHz CPU clock edges
//   want_bus                    : Pi control level requesting mastership
//   eng_busy                    : access engine is mid-cycle
//   nbg/nas/ndtack/nbgack/nreset_sync : synchronized 68000 bus signals
//   br_oe, bgack_oe             : drive nBR / nBGACK low
//   bus_owned                   : engine may start cycles
//   grant_tmo, abort_flag       : sticky status, cleared in idle once want_bus drops
//   arb_state                   : current state code for Pi status/debug
module m68k_bus_arbiter
   import m68k_bus_arbiter_pkg::*;
#(
   parameter int unsigned GRANT_TIMEOUT = 255,
   parameter int unsigned TMO_W         = 8
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       mc_clk_rising,
   input  logic       mc_clk_falling,
   input  logic       want_bus,
   input  logic       eng_busy,
   input  logic       nbg_sync,
   input  logic       nas_sync,
   input  logic       ndtack_sync,
   input  logic       nbgack_sync,
   input  logic       nreset_sync,
   output logic       br_oe,
   output logic       bgack_oe,
   output logic       bus_owned,
   output logic       grant_tmo,
   output logic       abort_flag,
   output logic [2:0] arb_state
);

   localparam logic             TMO_EN   = GRANT_TIMEOUT != 0;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(GRANT_TIMEOUT - 1);
   localparam logic [TMO_W-1:0] CNT_MAX  = '1;

   arb_state_e       state_q, state_d;
   logic             br_oe_q, br_oe_d;
   logic             bgack_oe_q, bgack_oe_d;
   logic             bus_owned_q, bus_owned_d;
   logic             grant_tmo_q, grant_tmo_d;
   logic             abort_flag_q, abort_flag_d;
   logic [TMO_W-1:0] cnt_q, cnt_d;

   always_comb begin
      state_d      = state_q;
      br_oe_d      = br_oe_q;
      bgack_oe_d   = bgack_oe_q;
      bus_owned_d  = bus_owned_q;
      grant_tmo_d  = grant_tmo_q;
      abort_flag_d = abort_flag_q;
      cnt_d        = cnt_q;
      case (state_q)
         ST_IDLE: begin
            // A set flag blocks re-requesting until the Pi acknowledges by dropping want_bus.
            if (!want_bus) begin
               grant_tmo_d  = 1'b0;
               abort_flag_d = 1'b0;
            end else if (!grant_tmo_q && !abort_flag_q) begin
               br_oe_d = 1'b1;
               cnt_d   = '0;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            // Withdrawal is tested first so a BG arriving on the same edge is ignored.
            if (mc_clk_falling) begin
               if (!want_bus) begin
                  br_oe_d = 1'b0;
                  state_d = ST_IDLE;
               end else if (!nbg_sync) begin
                  state_d = ST_WAIT_FREE;
               end else if (TMO_EN && cnt_q == TMO_LAST) begin
                  br_oe_d     = 1'b0;
                  grant_tmo_d = 1'b1;
                  state_d     = ST_IDLE;
               end else begin
                  cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
               end
            end
         end
         ST_WAIT_FREE: begin
            if (mc_clk_falling && bus_quiet(nas_sync, ndtack_sync, nbgack_sync)) begin
               bgack_oe_d = 1'b1;
               state_d    = ST_ACQ;
            end
         end
         ST_ACQ: begin
            // BR is released half a CPU clock after BGACK asserts so the two overlap.
            if (mc_clk_rising) begin
               br_oe_d     = 1'b0;
               bus_owned_d = 1'b1;
               state_d     = ST_OWNED;
            end
         end
         ST_OWNED: begin
            // An engine cycle in flight is always allowed to finish.
            if (!want_bus && !eng_busy) begin
               bus_owned_d = 1'b0;
               state_d     = ST_REL;
            end
         end
         ST_REL: begin
            if (mc_clk_falling) begin
               bgack_oe_d = 1'b0;
               state_d    = ST_IDLE;
            end
         end
         default: begin
            br_oe_d     = 1'b0;
            bgack_oe_d  = 1'b0;
            bus_owned_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
      // A bus reset while holding or seeking the bus drops everything at once, even mid-cycle.
      if (state_q != ST_IDLE && !nreset_sync) begin
         br_oe_d      = 1'b0;
         bgack_oe_d   = 1'b0;
         bus_owned_d  = 1'b0;
         abort_flag_d = 1'b1;
         state_d      = ST_IDLE;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q      <= ST_IDLE;
         br_oe_q      <= 1'b0;
         bgack_oe_q   <= 1'b0;
         bus_owned_q  <= 1'b0;
         grant_tmo_q  <= 1'b0;
         abort_flag_q <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         br_oe_q      <= br_oe_d;
         bgack_oe_q   <= bgack_oe_d;
         bus_owned_q  <= bus_owned_d;
         grant_tmo_q  <= grant_tmo_d;
         abort_flag_q <= abort_flag_d;
         cnt_q        <= cnt_d;
      end
   end

   assign br_oe      = br_oe_q;
   assign bgack_oe   = bgack_oe_q;
   assign bus_owned  = bus_owned_q;
   assign grant_tmo  = grant_tmo_q;
   assign abort_flag = abort_flag_q;
   assign arb_state  = state_q;

endmodule
